uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 12 +
 rtl/tx_queue_ram.sv | 21 ++
 rtl/uart_tx_queue.sv | 95 +++++++++
 tb/tb_uart_tx_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default sizing for the UART transmit queue.
package uart_pkg;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_TIMEOUT_CYC = 4;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_t;
endpackage

// File: rtl/tx_queue_ram.sv
// tx_queue_ram: single-clock byte RAM with registered read, shaped to infer iCE40 BRAM.
module tx_queue_ram
  import uart_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wa,
  input  logic [7:0]           wd,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] ra,
  output logic [7:0]           rd
);
  logic [7:0] mem [0:(1<<ADDR_BITS)-1];
  // read-first: a pop and a push to the same slot (queue full) returns the old byte
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART core through a launch/handshake FSM.
// Define UART_TX_QUEUE_LEVEL_EN to add the level (fill count) output.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             drained,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_busy
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  output logic [ADDR_BITS:0] level
`endif
);
  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(1) << ADDR_BITS;
  tx_state_t state;
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0] count, count_nx;
  logic [7:0] rd_data;
  logic [15:0] tmo;
  logic tx_valid_q, pop, push;
  tx_queue_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk(clk),
    .we (push),
    .wa (wr_ptr),
    .wd (wr_data),
    .re (pop),
    .ra (rd_ptr),
    .rd (rd_data)
  );
  always_comb begin
    pop = state == ST_IDLE && !empty && !tx_busy && !flush;
    push = wr_en && !flush && (!full || pop);
    count_nx = flush ? '0 : count + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
  end
  // a flush in the launch cycle suppresses the already-registered strobe
  assign tx_valid = tx_valid_q && !flush;
  assign drained = empty && state == ST_IDLE && !tx_busy;
`ifdef UART_TX_QUEUE_LEVEL_EN
  assign level = count;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      overflow <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data <= 8'h00;
      tmo <= '0;
    end else begin
      count <= count_nx;
      empty <= count_nx == '0;
      full <= count_nx == DEPTH;
      wr_ptr <= flush ? '0 : wr_ptr + ADDR_BITS'(push);
      rd_ptr <= flush ? '0 : rd_ptr + ADDR_BITS'(pop);
      overflow <= !flush && (overflow || (wr_en && full && !pop));
      tx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: state <= pop ? ST_FETCH : ST_IDLE;
        ST_FETCH:
          if (flush) state <= ST_IDLE;
          else begin
            tx_data <= rd_data;
            tx_valid_q <= 1'b1;
            state <= ST_LAUNCH;
          end
        ST_LAUNCH: begin
          state <= flush ? ST_IDLE : ST_WAIT_BUSY;
          tmo <= '0;
        end
        ST_WAIT_BUSY:
          if (tx_busy) state <= ST_WAIT_DONE;
          else if (tmo == 16'(TIMEOUT_CYC - 1)) state <= ST_IDLE;
          else tmo <= tmo + 16'd1;
        ST_WAIT_DONE: state <= tx_busy ? ST_WAIT_DONE : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed stimulus with a queue/timestamp reference model checked every cycle.
module tb_uart_tx_queue;
  localparam int AB = 8;
  localparam int TMO = 4;
  localparam int DEPTH = 1 << AB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic flush = 1'b0;
  logic full, empty, overflow, drained, tx_valid;
  logic [7:0] tx_data;
  logic busy_force = 1'b0;
  logic busy_uart = 1'b0;
  logic auto = 1'b0;
  logic tx_busy;
  assign tx_busy = busy_force | busy_uart;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [AB:0] level;
`endif
  int total = 0;
  int bad = 0;
  uart_tx_queue #(.ADDR_BITS(AB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .flush(flush),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .drained(drained),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_busy(tx_busy)
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    .level(level)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drained(input string nm, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      @(negedge clk);
      ok = drained;
    end
    chk(nm, 32'(ok), 1);
  endtask
  // UART stand-in: busy for three cycles starting the cycle after each strobe
  initial forever begin
    @(negedge clk);
    if (auto && tx_valid) begin
      tick();
      busy_uart = 1'b1;
      repeat (3) tick();
      busy_uart = 1'b0;
    end
  end
  // Reference: byte queue plus launch/deadline timestamps, evaluated once per cycle
  logic [7:0] q[$];
  logic [7:0] txd_m = 8'h00;
  logic [7:0] pend_b = 8'h00;
  bit ovf_m = 0, pend = 0, wrise = 0, wfall = 0, ref_ok = 0;
  int cyc = 0, launch_at = 0, deadline = 0;
  initial forever begin
    bit idle, pop, was_full;
    @(negedge clk);
    idle = !pend && !wrise && !wfall;
    if (ref_ok) begin
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("tx_valid", 32'(tx_valid), 32'(pend && cyc == launch_at && !flush));
      chk("tx_data", 32'(tx_data), 32'(txd_m));
      chk("drained", 32'(drained), 32'(q.size() == 0 && idle && !tx_busy));
`ifdef UART_TX_QUEUE_LEVEL_EN
      chk("level", 32'(level), 32'(q.size()));
`endif
    end
    if (reset) begin
      q.delete();
      ovf_m = 0;
      txd_m = 8'h00;
      pend = 0;
      wrise = 0;
      wfall = 0;
      ref_ok = 1;
    end else begin
      pop = idle && q.size() > 0 && !tx_busy && !flush;
      was_full = q.size() == DEPTH;
      if (pend) begin
        if (flush) pend = 0;
        else if (cyc == launch_at - 1) txd_m = pend_b;
        else if (cyc == launch_at) begin
          pend = 0;
          wrise = 1;
          deadline = cyc + TMO;
        end
      end else if (wrise) begin
        if (tx_busy) begin
          wrise = 0;
          wfall = 1;
        end else if (cyc == deadline) wrise = 0;
      end else if (wfall && !tx_busy) wfall = 0;
      if (pop) begin
        pend_b = q.pop_front();
        pend = 1;
        launch_at = cyc + 2;
      end
      if (flush) begin
        q.delete();
        ovf_m = 0;
      end else if (wr_en) begin
        if (!was_full || pop) q.push_back(wr_data);
        else ovf_m = 1;
      end
    end
    cyc++;
  end
  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int lc[2];
    logic [7:0] ld[2];
    logic [7:0] got[300];
    int n, errs;
    bit done;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drained", 32'(drained), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    // single byte into an idle queue: strobe three cycles after the push
    auto = 1'b1;
    tick();
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", 32'(tx_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_c2_valid", 32'(tx_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_c3_valid", 32'(tx_valid), 1);
    chk("lat_c3_data", 32'(tx_data), 32'h55);
    wait_drained("drained_after_55", 20);
    // busy never rises: four-cycle timeout, then the next byte launches
    auto = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      wr_en = i < 2;
      wr_data = (i == 0) ? 8'hA1 : 8'hA2;
      @(negedge clk);
      if (tx_valid && n < 2) begin
        lc[n] = i;
        ld[n] = tx_data;
        n++;
      end
    end
    chk("tmo_launches", 32'(n), 2);
    chk("tmo_first_cyc", 32'(lc[0]), 3);
    chk("tmo_second_cyc", 32'(lc[1]), 10);
    chk("tmo_first_data", 32'(ld[0]), 32'hA1);
    chk("tmo_second_data", 32'(ld[1]), 32'hA2);
    wait_drained("drained_after_tmo", 10);
    // fill to 256 with the UART busy, overflow on the 257th, then push+pop while full
    busy_force = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      wr_en = 1'b1;
      wr_data = 8'(i);
    end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("fill_full", 32'(full), 1);
    chk("fill_no_ovf", 32'(overflow), 0);
    tick();
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_full", 32'(full), 1);
    tick();
    wr_en = 1'b1;
    wr_data = 8'hAA;
    busy_force = 1'b0;
    auto = 1'b1;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("simul_full", 32'(full), 1);
`ifdef UART_TX_QUEUE_LEVEL_EN
    chk("simul_level", 32'(level), 256);
`endif
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 2400 && !done; i++) begin
      tick();
      @(negedge clk);
      if (tx_valid && n < 300) begin
        got[n] = tx_data;
        n++;
      end
      done = drained;
    end
    chk("drain_done", 32'(done), 1);
    chk("drain_count", 32'(n), 257);
    errs = 0;
    for (int i = 0; i < 256; i++) if (got[i] !== 8'(i)) errs++;
    chk("drain_order", 32'(errs), 0);
    chk("drain_last", 32'(got[256]), 32'hAA);
    // flush during FETCH with ten bytes queued
    auto = 1'b0;
    busy_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      wr_en = 1'b1;
      wr_data = 8'(i + 16);
    end
    tick();
    wr_en = 1'b0;
    busy_force = 1'b0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_fetch_valid", 32'(tx_valid), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_valid", 32'(tx_valid), 0);
    chk("flush_data_held", 32'(tx_data), 32'hAA);
    tick();
    wr_en = 1'b1;
    flush = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_push_dropped", 32'(empty), 1);
    // reset while waiting for busy to fall, with a second byte still queued
    tick();
    wr_en = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_data = 8'h3D;
    tick();
    wr_en = 1'b0;
    tick();
    @(negedge clk);
    chk("rst40_launch", 32'(tx_valid), 1);
    chk("rst40_data", 32'(tx_data), 32'h3C);
    tick();
    busy_force = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    busy_force = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst40_valid", 32'(tx_valid), 0);
    chk("rst40_empty", 32'(empty), 1);
    chk("rst40_full", 32'(full), 0);
    chk("rst40_ovf", 32'(overflow), 0);
    chk("rst40_drained", 32'(drained), 1);
    chk("rst40_tx_data", 32'(tx_data), 0);
    repeat (10) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
